requant_relu_sat: RTL and testbench
===================================

# requant_relu_sat

Streaming requantization stage placed directly downstream of the serial vector convolution stage. It takes the wide signed accumulator-plus-bias words, applies rounding, an arithmetic right shift, optional ReLU and saturation, and produces OUT_WIDTH-bit activations for the next layer's line buffer. It realigns the late frame markers onto their packet markers. It also checks line and frame framing, raising a sticky error on violations.

## Interface
- IN_WIDTH, 24: input word width (kernel + data + accumulation growth), signed.
- OUT_WIDTH, 8: output activation width, signed.
- SHIFT, 8: right-shift amount, range 0..IN_WIDTH-1.
- RELU, 1: 1 clamps negatives to 0; 0 saturates to the signed minimum.
- LINE_LEN, 224: valid words per line (sop..eop inclusive).
- LINE_NUM, 224: lines per frame.
- SOF_LAG, 1: cycles by which sof_i/eof_i trail their sop_i/eop_i; 0 or 1.

Ports:
- clk, input, 1: clock.
- reset_n, input, 1: reset, asynchronous, active-low.
- data_i, input, IN_WIDTH: signed input word.
- valid_i, input, 1: data_i qualifier.
- sop_i / eop_i, input, 1 each: first / last word of a line, valid-qualified.
- sof_i / eof_i, input, 1 each: frame start / end markers, arriving SOF_LAG cycles after sop_i / eop_i.
- err_clr_i, input, 1: clears err_o.
- data_o, output, OUT_WIDTH: signed activation.
- valid_o, sop_o, eop_o, sof_o, eof_o, output, 1 each: realigned qualifiers. sof_o is coincident with sop_o, and eof_o is coincident with eop_o.
- err_o, output, 1: sticky framing error.

## Operation
- Datapath stage 1: sum = data_i + (1 << (SHIFT-1)), computed in IN_WIDTH+1 bits, so it cannot overflow. With SHIFT=0 the offset is 0.
- Datapath stage 2: sh = sum >>> SHIFT (arithmetic shift, floor).
- Datapath stage 3:
  - If sh > 2^(OUT_WIDTH-1)-1, the result is the maximum.
  - If sh < 0 and RELU=1, the result is 0.
  - If sh < -2^(OUT_WIDTH-1) and RELU=0, the result is the minimum.
  - Otherwise the result is sh truncated to OUT_WIDTH.
- Marker alignment:
  - sop_i and eop_i are delayed SOF_LAG extra cycles.
  - sof_o = delayed sop AND sof_i; eof_o = delayed eop AND eof_i.
  - A sof_i or eof_i with no matching delayed sop or eop is a framing error and is not forwarded.
- Framing checker FSM states: IDLE, GAP, LINE.
  - IDLE: a word with sop and sof moves to LINE with pix=1 and line=1.
  - GAP: a word with sop moves to LINE with pix=1 and line+1.
  - LINE: each valid word increments pix. eop at pix==LINE_LEN moves to GAP, or to IDLE when line==LINE_NUM and eof is present.
- Errors (each sets err_o):
  - valid without sop in IDLE or GAP;
  - sop in LINE;
  - eop at pix != LINE_LEN;
  - pix reaching LINE_LEN without eop;
  - sof outside IDLE;
  - eof at line != LINE_NUM or without eop;
  - missing eof at the last line.
- Recovery: on error the FSM goes to IDLE, except that a sop on the erroring word restarts LINE. The datapath is never gated by the checker; data always flows.
- err_clr_i clears err_o. A new error in the same cycle wins, and err_o stays 1.

## Timing
- Latency from valid_i to valid_o is 3 + SOF_LAG cycles. All qualifiers experience identical latency.
- Throughput: one word per cycle. There is no backpressure.
- err_o is registered and rises 1 cycle after the offending input is evaluated (SOF_LAG cycles after the word for sof/eof checks).
- Reset state:
  - All outputs 0; FSM in IDLE; counters 0.
  - Pipeline valid bits are cleared asynchronously. Data registers are don't-care.
  - Reset mid-frame drops in-flight words. After reset the block resumes at the next sof.

## Configuration
- REQUANT_ROUND_EN defined: the stage-1 half-LSB rounding offset is added (round half up).
- REQUANT_ROUND_EN undefined: the offset is 0 (pure floor). Latency and widths are unchanged; stage 1 becomes a plain register.

## Structure
- Package requant_pkg holds:
  - enum typedef frm_state_t {IDLE, GAP, LINE};
  - function sat_relu(value, relu), parameterized by width through localparams in the user module;
  - localparam SOF_LAG_MAX = 1.
- Sub-module frame_chk contains the FSM, pix/line counters, error logic and err_clr. The top instantiates it beside the datapath pipeline.

## Test plan
- IN_WIDTH=24, SHIFT=8, RELU=1, data 384: with REQUANT_ROUND_EN → 2; without → 1; output after 4 cycles.
- Data 0x7FFFFF → 127. Data -1000 → 0 with RELU=1; → -4 with RELU=0 and rounding (-872 >>> 8).
- LINE_LEN=4, LINE_NUM=2, SOF_LAG=1, clean frame: sof_o coincides with the first sop_o, eof_o with the last eop_o; err_o stays 0.
- LINE_LEN=4 with eop on the 3rd word → err_o=1 the next cycle; stays 1 until err_clr_i. err_clr_i applied together with a new error leaves err_o at 1.
- sop arriving mid-line → err_o=1, and the checker restarts the line. The following clean line passes unflagged apart from the sticky bit.
- reset_n low for 1 cycle mid-line → all outputs 0 immediately. The next full frame produces correct sof_o/eof_o with no error.

Source files
------------

// File: rtl/requant_pkg.sv
// requant_pkg: shared types, limits and the saturation helper for the requantization stage.
//   SOF_LAG_MAX  largest supported lag of sof/eof behind sop/eop
//   frm_state_t  framing checker states
//   sat_relu     clamps a signed value to a w-bit signed range, or to [0, max] when relu is set
package requant_pkg;
   localparam int SOF_LAG_MAX = 1;
   typedef enum logic [1:0] {IDLE, GAP, LINE} frm_state_t;
   // Works on a 64-bit sign-extended value; the caller casts the result down to w bits.
   function automatic logic signed [63:0] sat_relu(input logic signed [63:0] value, input logic relu, input int w = 8);
      logic signed [63:0] mx, mn;
      mx = (64'sd1 <<< (w - 1)) - 64'sd1;
      mn = -mx - 64'sd1;
      return value > mx ? mx : (relu && value < 64'sd0) ? 64'sd0 : value < mn ? mn : value;
   endfunction
endpackage

// File: rtl/frame_chk.sv
// frame_chk: line/frame framing checker with a sticky error flag.
//   clk, reset_n                 clock, asynchronous active-low reset
//   valid, sop, eop              word qualifiers as they enter the block
//   sof, eof                     frame markers, trailing sop/eop by SOF_LAG cycles
//   err_clr                      clears err (a new error in the same cycle wins)
//   err                          sticky framing error
module frame_chk import requant_pkg::*; #(
   parameter int LINE_LEN = 224,
   parameter int LINE_NUM = 224,
   parameter int SOF_LAG  = 1
) (
   input  logic clk,
   input  logic reset_n,
   input  logic valid,
   input  logic sop,
   input  logic eop,
   input  logic sof,
   input  logic eof,
   input  logic err_clr,
   output logic err
);
   localparam int PW = $clog2(LINE_LEN + 1);
   localparam int LW = $clog2(LINE_NUM + 1);
   localparam logic [PW-1:0] LEN = PW'(LINE_LEN);
   localparam logic [LW-1:0] NUM = LW'(LINE_NUM);
   frm_state_t state, state_n, st;
   logic [PW-1:0] pix, pix_n, pn;
   logic [LW-1:0] line, line_n, ls, ln;
   logic start_r, last_r, start_w, last_w, start_l, last_l, go, act, rs, err_n;
   // Word checks run on the word as it arrives; sof/eof checks run SOF_LAG cycles later
   // against what the word looked like (frame start candidate / last-line eop).
   // A frame start taken from IDLE is provisional until its sof shows up; without it
   // the checker falls back to IDLE.
   always_comb begin
      st = (SOF_LAG != 0 && start_r && !sof) ? IDLE : state;
      rs = valid && sop;
      go = rs && (st == GAP || (st == IDLE && (SOF_LAG != 0 || sof)));
      act = go || (valid && !sop && st == LINE);
      pn = go ? PW'(1) : pix + PW'(1);
      ls = st == IDLE ? LW'(1) : st == GAP ? line + LW'(1) : line;
      ln = go ? ls : line;
      start_w = rs && st == IDLE;
      last_w = act && eop && ln == NUM;
      start_l = SOF_LAG != 0 ? start_r : start_w;
      last_l = SOF_LAG != 0 ? last_r : last_w;
      err_n = (valid && !sop && st != LINE) || (rs && st == LINE) || (act && (eop != (pn == LEN)))
            || (sof && !start_l) || (eof && !last_l) || (last_l && !eof);
      // Errors drop to IDLE unless the erroring word carries sop, which restarts the line.
      state_n = err_n ? (rs ? LINE : IDLE) : !act ? st : !eop ? LINE : ln == NUM ? IDLE : GAP;
      pix_n = err_n ? (rs ? PW'(1) : '0) : !act ? pix : eop ? '0 : pn;
      line_n = err_n ? (rs ? ls : '0) : !act ? line : (eop && ln == NUM) ? '0 : ln;
   end
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         state <= IDLE;
         pix <= '0;
         line <= '0;
         start_r <= 1'b0;
         last_r <= 1'b0;
         err <= 1'b0;
      end else begin
         state <= state_n;
         pix <= pix_n;
         line <= line_n;
         start_r <= start_w;
         last_r <= last_w;
         err <= err_n || (err && !err_clr);
      end
endmodule

// File: rtl/requant_relu_sat.sv
// requant_relu_sat: round, arithmetic shift, ReLU/saturate wide accumulator words to activations,
// realign trailing sof/eof onto sop/eop and check framing.
//   clk, reset_n                        clock, asynchronous active-low reset
//   data_i, valid_i, sop_i, eop_i       signed input word and its qualifiers
//   sof_i, eof_i                        frame markers, SOF_LAG cycles behind sop_i/eop_i
//   err_clr_i                           clears err_o
//   data_o, valid_o, sop_o, eop_o       activation and qualifiers, 3 + SOF_LAG cycles later
//   sof_o, eof_o                        frame markers coincident with sop_o/eop_o
//   err_o                               sticky framing error
// Build option: define REQUANT_ROUND_EN to add the half-LSB rounding offset before the shift.
module requant_relu_sat import requant_pkg::*; #(
   parameter int IN_WIDTH  = 24,
   parameter int OUT_WIDTH = 8,
   parameter int SHIFT     = 8,
   parameter int RELU      = 1,
   parameter int LINE_LEN  = 224,
   parameter int LINE_NUM  = 224,
   parameter int SOF_LAG   = 1
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [IN_WIDTH-1:0]  data_i,
   input  logic                 valid_i,
   input  logic                 sop_i,
   input  logic                 eop_i,
   input  logic                 sof_i,
   input  logic                 eof_i,
   input  logic                 err_clr_i,
   output logic [OUT_WIDTH-1:0] data_o,
   output logic                 valid_o,
   output logic                 sop_o,
   output logic                 eop_o,
   output logic                 sof_o,
   output logic                 eof_o,
   output logic                 err_o
);
   localparam int LAG = SOF_LAG > SOF_LAG_MAX ? SOF_LAG_MAX : SOF_LAG;
`ifdef REQUANT_ROUND_EN
   localparam logic [IN_WIDTH:0] RND = (SHIFT == 0) ? '0 : (IN_WIDTH + 1)'(1) << (SHIFT == 0 ? 0 : SHIFT - 1);
`else
   localparam logic [IN_WIDTH:0] RND = '0;
`endif
   logic [IN_WIDTH-1:0] d0;
   logic v0, sp0, ep0;
   logic signed [IN_WIDTH:0] s1, s2;
   logic [4:0] c1, c2, c3;
   logic [OUT_WIDTH-1:0] q;
   // Word and sop/eop wait here so the trailing sof/eof line up with them.
   generate
      if (LAG != 0) begin : g_lag
         always_ff @(posedge clk or negedge reset_n)
            if (!reset_n) {v0, sp0, ep0} <= '0;
            else {v0, sp0, ep0} <= {valid_i, valid_i && sop_i, valid_i && eop_i};
         always_ff @(posedge clk)
            d0 <= data_i;
      end else begin : g_now
         assign {v0, sp0, ep0} = {valid_i, valid_i && sop_i, valid_i && eop_i};
         assign d0 = data_i;
      end
   endgenerate
   // Control bundle {valid, sop, eop, sof, eof}; unmatched sof/eof are dropped here.
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         c1 <= '0;
         c2 <= '0;
         c3 <= '0;
         q <= '0;
      end else begin
         c1 <= {v0, sp0, ep0, sp0 && sof_i, ep0 && eof_i};
         c2 <= c1;
         c3 <= c2;
         q <= OUT_WIDTH'(sat_relu(64'(s2), RELU != 0, OUT_WIDTH));
      end
   // One extra bit of headroom keeps the rounding add from overflowing.
   always_ff @(posedge clk) begin
      s1 <= {d0[IN_WIDTH-1], d0} + RND;
      s2 <= s1 >>> SHIFT;
   end
   assign {valid_o, sop_o, eop_o, sof_o, eof_o} = c3;
   assign data_o = q;
   frame_chk #(
      .LINE_LEN(LINE_LEN),
      .LINE_NUM(LINE_NUM),
      .SOF_LAG (LAG)
   ) u_chk (
      .clk    (clk),
      .reset_n(reset_n),
      .valid  (valid_i),
      .sop    (sop_i),
      .eop    (eop_i),
      .sof    (sof_i),
      .eof    (eof_i),
      .err_clr(err_clr_i),
      .err    (err_o)
   );
endmodule

// File: tb/tb_requant_relu_sat.sv
// tb_requant_relu_sat: directed checks of requant_relu_sat (LINE_LEN=4, LINE_NUM=2, SOF_LAG=1), RELU=1 and RELU=0.
module tb_requant_relu_sat;
`ifdef REQUANT_ROUND_EN
   localparam logic [7:0] R384 = 8'd2;
`else
   localparam logic [7:0] R384 = 8'd1;
`endif
   logic clk = 1'b0, reset_n = 1'b0;
   logic [23:0] data_i;
   logic valid_i, sop_i, eop_i, sof_i, eof_i, err_clr_i;
   logic [7:0] data_o, data0_o;
   logic valid_o, sop_o, eop_o, sof_o, eof_o, err_o;
   logic valid0_o, sop0_o, eop0_o, sof0_o, eof0_o, err0_o;
   int checks = 0, failures = 0;
   // input rows {valid, sop, eop, sof, eof}; sof/eof trail their sop/eop by one row
   logic [4:0] row_ctl [9] = '{5'b11000, 5'b10010, 5'b10000, 5'b10100, 5'b11000,
                               5'b10000, 5'b10000, 5'b10100, 5'b00001};
   logic [23:0] row_d [9] = '{24'd384, 24'h7FFFFF, -24'sd1000, 24'd0, 24'd32767,
                              24'd2560, -24'sd32768, -24'sd40000, 24'd0};
   logic [4:0] exp_ctl [9] = '{5'b11010, 5'b10000, 5'b10000, 5'b10100, 5'b11000,
                               5'b10000, 5'b10000, 5'b10101, 5'b00000};
   logic [7:0] exp_d [8] = '{R384, 8'h7F, 8'h00, 8'h00, 8'h7F, 8'h0A, 8'h00, 8'h00};
   logic [7:0] exp_d0 [8] = '{R384, 8'h7F, 8'hFC, 8'h00, 8'h7F, 8'h0A, 8'h80, 8'h80};
   always #5 clk = ~clk;
   requant_relu_sat #(.LINE_LEN(4), .LINE_NUM(2), .SOF_LAG(1), .RELU(1)) dut (
      .clk(clk), .reset_n(reset_n), .data_i(data_i), .valid_i(valid_i), .sop_i(sop_i),
      .eop_i(eop_i), .sof_i(sof_i), .eof_i(eof_i), .err_clr_i(err_clr_i), .data_o(data_o),
      .valid_o(valid_o), .sop_o(sop_o), .eop_o(eop_o), .sof_o(sof_o), .eof_o(eof_o), .err_o(err_o)
   );
   requant_relu_sat #(.LINE_LEN(4), .LINE_NUM(2), .SOF_LAG(1), .RELU(0)) dut0 (
      .clk(clk), .reset_n(reset_n), .data_i(data_i), .valid_i(valid_i), .sop_i(sop_i),
      .eop_i(eop_i), .sof_i(sof_i), .eof_i(eof_i), .err_clr_i(err_clr_i), .data_o(data0_o),
      .valid_o(valid0_o), .sop_o(sop0_o), .eop_o(eop0_o), .sof_o(sof0_o), .eof_o(eof0_o), .err_o(err0_o)
   );
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic drive(input logic v, s, e, f, g, input logic [23:0] d);
      valid_i = v;
      sop_i = s;
      eop_i = e;
      sof_i = f;
      eof_i = g;
      data_i = d;
   endtask
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   // Clean two-line frame; row r shows up at the outputs after the 4th edge.
   task automatic frame;
      for (int t = 0; t < 12; t++) begin
         if (t < 9) drive(row_ctl[t][4], row_ctl[t][3], row_ctl[t][2], row_ctl[t][1], row_ctl[t][0], row_d[t]);
         else drive(0, 0, 0, 0, 0, 0);
         tick;
         if (t >= 3) begin
            chk($sformatf("ctl%0d", t - 3), {valid_o, sop_o, eop_o, sof_o, eof_o}, exp_ctl[t - 3]);
            chk($sformatf("ctl0_%0d", t - 3), {valid0_o, sop0_o, eop0_o, sof0_o, eof0_o}, exp_ctl[t - 3]);
            if (t < 11) begin
               chk($sformatf("data%0d", t - 3), data_o, exp_d[t - 3]);
               chk($sformatf("data0_%0d", t - 3), data0_o, exp_d0[t - 3]);
            end
         end
      end
      chk("frame_err", err_o, 0);
      chk("frame_err0", err0_o, 0);
   endtask
   initial begin
      err_clr_i = 1'b0;
      drive(0, 0, 0, 0, 0, 0);
      tick;
      tick;
      chk("reset_ctl", {valid_o, sop_o, eop_o, sof_o, eof_o}, 0);
      chk("reset_data", data_o, 0);
      chk("reset_err", err_o, 0);
      reset_n = 1'b1;
      frame;
      // eop on the 3rd word of a 4-word line
      drive(1, 1, 0, 0, 0, 5);
      tick;
      drive(1, 0, 0, 1, 0, 5);
      tick;
      chk("eop_pre", err_o, 0);
      drive(1, 0, 1, 0, 0, 5);
      tick;
      chk("eop_err", err_o, 1);
      drive(0, 0, 0, 0, 0, 0);
      tick;
      tick;
      chk("eop_sticky", err_o, 1);
      err_clr_i = 1'b1;
      drive(1, 0, 0, 0, 0, 5);
      tick;
      chk("clr_vs_new_err", err_o, 1);
      drive(0, 0, 0, 0, 0, 0);
      tick;
      chk("clr", err_o, 0);
      err_clr_i = 1'b0;
      // sop in the middle of a line restarts it
      drive(1, 1, 0, 0, 0, 7);
      tick;
      drive(1, 0, 0, 1, 0, 7);
      tick;
      drive(1, 1, 0, 0, 0, 7);
      tick;
      chk("midsop_err", err_o, 1);
      err_clr_i = 1'b1;
      drive(1, 0, 0, 0, 0, 7);
      tick;
      err_clr_i = 1'b0;
      chk("midsop_clr", err_o, 0);
      drive(1, 0, 0, 0, 0, 7);
      tick;
      drive(1, 0, 1, 0, 0, 7);
      tick;
      drive(1, 1, 0, 0, 0, 7);
      tick;
      drive(1, 0, 0, 0, 0, 7);
      tick;
      drive(1, 0, 0, 0, 0, 7);
      tick;
      drive(1, 0, 1, 0, 0, 7);
      tick;
      drive(0, 0, 0, 0, 1, 0);
      tick;
      drive(0, 0, 0, 0, 0, 0);
      tick;
      tick;
      chk("midsop_eof", {eop_o, eof_o}, 2'b11);
      chk("midsop_clean", err_o, 0);
      // reset in the middle of a line
      drive(1, 1, 0, 0, 0, 24'h1000);
      tick;
      drive(1, 0, 0, 1, 0, 24'h1000);
      tick;
      drive(1, 0, 0, 0, 0, 24'h1000);
      tick;
      drive(1, 0, 0, 0, 0, 24'h1000);
      tick;
      chk("pre_rst_ctl", {valid_o, sop_o, sof_o}, 3'b111);
      chk("pre_rst_data", data_o, 8'h10);
      drive(0, 0, 0, 0, 0, 0);
      reset_n = 1'b0;
      #1;
      chk("rst_ctl", {valid_o, sop_o, eop_o, sof_o, eof_o}, 0);
      chk("rst_data", data_o, 0);
      chk("rst_err", err_o, 0);
      tick;
      reset_n = 1'b1;
      frame;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
